// File: rtl/chroma_key_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : chroma_key_compositor
//  Description : Green-screen keying stage for an RGB pixel stream. Key
//                pixels are replaced according to a per-frame mode. Key
//                pixels are counted per frame, and the count is reported
//                together with a completed-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module chroma_key_compositor #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iR,
    input  logic [DATA_W-1:0] iG,
    input  logic [DATA_W-1:0] iB,
    input  logic              iDVAL,
    input  logic              iFVAL,
    input  logic [DATA_W-1:0] iBG_R,
    input  logic [DATA_W-1:0] iBG_G,
    input  logic [DATA_W-1:0] iBG_B,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iG_MIN,
    input  logic [DATA_W-1:0] iMARGIN,
    output logic [DATA_W-1:0] oR,
    output logic [DATA_W-1:0] oG,
    output logic [DATA_W-1:0] oB,
    output logic              oDVAL,
    output logic              oKEY,
    output logic [CNT_W-1:0]  oKEY_COUNT,
    output logic              oFRAME_DONE,
    output logic [CNT_W-1:0]  oFRAME_COUNT
);

    localparam logic [1:0]        c_MODE_PASS  = 2'd0;
    localparam logic [1:0]        c_MODE_BLACK = 2'd1;
    localparam logic [1:0]        c_MODE_BG    = 2'd2;
    localparam logic [1:0]        c_MODE_MASK  = 2'd3;
    localparam logic [DATA_W-1:0] c_ONES       = {DATA_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_MAX    = {CNT_W{1'b1}};

    // Shadow controls and frame-start detection
    logic              r_fval_prev;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_gmin;
    logic [DATA_W-1:0] r_margin;
    logic              r_armed;
    logic              w_rise;
    logic [DATA_W-1:0] w_margin;
    logic [DATA_W:0]   w_sr;
    logic [DATA_W:0]   w_sb;

    // Stage 1
    logic [DATA_W-1:0] r_r1, r_g1, r_b1;
    logic [DATA_W-1:0] r_bgr1, r_bgg1, r_bgb1;
    logic [DATA_W:0]   r_sr1, r_sb1;
    logic              r_dv1, r_fv1;

    // Stage 2
    logic [DATA_W-1:0] r_r2, r_g2, r_b2;
    logic [DATA_W-1:0] r_bgr2, r_bgg2, r_bgb2;
    logic              r_key2, r_dv2, r_fv2;
    logic [1:0]        r_mode2;
    logic              w_key;

    // Stage 3 / counting
    logic [DATA_W-1:0] w_or, w_og, w_ob;
    logic              r_fv3;
    logic [CNT_W-1:0]  r_acc;
    logic              w_inc;
    logic [CNT_W-1:0]  w_acc_sum;
    logic              w_fd_fall;

    assign w_rise = iFVAL & ~r_fval_prev;
    // The pixel arriving with the frame-start edge already uses the new margin
    assign w_margin = w_rise ? iMARGIN : r_margin;
    assign w_sr     = {1'b0, iR} + {1'b0, w_margin};
    assign w_sb     = {1'b0, iB} + {1'b0, w_margin};

    // Capture run-time controls at frame start so one frame sees one setting
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_fval_prev <= 1'b1;
            r_mode      <= c_MODE_PASS;
            r_gmin      <= c_ONES;
            r_margin    <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_fval_prev <= iFVAL;
            if (w_rise) begin
                r_mode   <= iMODE;
                r_gmin   <= iG_MIN;
                r_margin <= iMARGIN;
                r_armed  <= 1'b1;
            end
        end
    end

    // Stage 1: register pixel/background/valids and the widened threshold sums
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_r1   <= '0;
            r_g1   <= '0;
            r_b1   <= '0;
            r_bgr1 <= '0;
            r_bgg1 <= '0;
            r_bgb1 <= '0;
            r_sr1  <= '0;
            r_sb1  <= '0;
            r_dv1  <= 1'b0;
            r_fv1  <= 1'b1;
        end else begin
            r_r1   <= iR;
            r_g1   <= iG;
            r_b1   <= iB;
            r_bgr1 <= iBG_R;
            r_bgg1 <= iBG_G;
            r_bgb1 <= iBG_B;
            r_sr1  <= w_sr;
            r_sb1  <= w_sb;
            r_dv1  <= iDVAL;
            r_fv1  <= iFVAL;
        end
    end

    // Key decision; bubbles are never key, and passthrough mode never keys
    assign w_key = r_dv1 && (r_g1 >= r_gmin) &&
                   ({1'b0, r_g1} > r_sr1) && ({1'b0, r_g1} > r_sb1) &&
                   (r_mode != c_MODE_PASS);

    // Stage 2: register the key decision with the mode it was made under
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_r2    <= '0;
            r_g2    <= '0;
            r_b2    <= '0;
            r_bgr2  <= '0;
            r_bgg2  <= '0;
            r_bgb2  <= '0;
            r_key2  <= 1'b0;
            r_dv2   <= 1'b0;
            r_fv2   <= 1'b1;
            r_mode2 <= c_MODE_PASS;
        end else begin
            r_r2    <= r_r1;
            r_g2    <= r_g1;
            r_b2    <= r_b1;
            r_bgr2  <= r_bgr1;
            r_bgg2  <= r_bgg1;
            r_bgb2  <= r_bgb1;
            r_key2  <= w_key;
            r_dv2   <= r_dv1;
            r_fv2   <= r_fv1;
            r_mode2 <= r_mode;
        end
    end

    // Output pixel selection
    always_comb begin
        w_or = r_r2;
        w_og = r_g2;
        w_ob = r_b2;
        if (r_mode2 == c_MODE_MASK) begin
            w_or = r_key2 ? c_ONES : '0;
            w_og = r_key2 ? c_ONES : '0;
            w_ob = r_key2 ? c_ONES : '0;
        end else if (r_key2) begin
            case (r_mode2)
                c_MODE_BLACK: begin
                    w_or = '0;
                    w_og = '0;
                    w_ob = '0;
                end
                c_MODE_BG: begin
                    w_or = r_bgr2;
                    w_og = r_bgg2;
                    w_ob = r_bgb2;
                end
                default: begin
                    w_or = r_r2;
                    w_og = r_g2;
                    w_ob = r_b2;
                end
            endcase
        end
    end

    // Stage 3: registered outputs and the output-aligned frame valid (fd)
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oR    <= '0;
            oG    <= '0;
            oB    <= '0;
            oDVAL <= 1'b0;
            oKEY  <= 1'b0;
            r_fv3 <= 1'b1;
        end else begin
            oR    <= w_or;
            oG    <= w_og;
            oB    <= w_ob;
            oDVAL <= r_dv2;
            oKEY  <= r_key2;
            r_fv3 <= r_fv2;
        end
    end

    assign w_inc     = oDVAL & oKEY & r_fv3;
    assign w_acc_sum = (w_inc && (r_acc != c_CNT_MAX)) ? r_acc + CNT_W'(1) : r_acc;
    // fd is about to fall: the snapshot includes the last fd=1 pixel now on the outputs,
    // and the pulse appears in the first output cycle with fd=0
    assign w_fd_fall = r_fv3 & ~r_fv2;

    // Saturating per-frame key count and frame-end reporting
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_acc        <= '0;
            oKEY_COUNT   <= '0;
            oFRAME_COUNT <= '0;
            oFRAME_DONE  <= 1'b0;
        end else begin
            oFRAME_DONE <= 1'b0;
            if (w_fd_fall) begin
                r_acc <= '0;
                if (r_armed) begin
                    oKEY_COUNT   <= w_acc_sum;
                    oFRAME_DONE  <= 1'b1;
                    oFRAME_COUNT <= oFRAME_COUNT + CNT_W'(1);
                end
            end else begin
                r_acc <= w_acc_sum;
            end
        end
    end

endmodule
`default_nettype wire
